// File: rtl/homography_responder.sv
// Affine query responder: maps (x,y) through a Q8.8 2x3 transform and
// returns the RGB565 frame pixel at fixed latency. HOMO_OOB_CNT_EN adds oob_count.
module homography_responder #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int MEM_LAT = 2
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic [9:0]  query_x,
  input  logic [9:0]  query_y,
  input  logic        start,
  output logic [9:0]  return_x,
  output logic [9:0]  return_y,
  output logic [4:0]  r,
  output logic [5:0]  g,
  output logic [4:0]  b,
  output logic        ready,
  output logic        mem_rd,
  output logic [18:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        coef_wr,
  input  logic [2:0]  coef_sel,
  input  logic [19:0] coef_data,
  input  logic        coef_commit,
  output logic        commit_pending,
  output logic [15:0] oob_count
);

  localparam int L = MEM_LAT - 1;

  logic signed [15:0] sh_a, sh_b, sh_d, sh_e;
  logic signed [15:0] ac_a, ac_b, ac_d, ac_e;
  logic signed [19:0] sh_c, sh_f, ac_c, ac_f;

  logic               s1_v;
  logic [9:0]         s1_x, s1_y;
  logic               s2_v;
  logic [9:0]         s2_x, s2_y;
  logic signed [26:0] p_ax, p_by, p_dx, p_ey;
  logic               s3_v, s3_oob;
  logic [9:0]         s3_x, s3_y;
  logic [18:0]        s3_addr;

  logic [MEM_LAT-1:0]       tag_v, tag_oob;
  logic [MEM_LAT-1:0][9:0]  tag_x, tag_y;

  logic busy, do_copy;

  logic signed [26:0] xe, ye, a27, b27, d27, e27;
  logic signed [28:0] sum_x, sum_y;
  logic signed [20:0] sx, sy;
  logic               oob_c;
  logic [18:0]        addr_c;
  logic               unused_lsb;

  assign busy    = s1_v | s2_v | s3_v | (|tag_v) | ready;
  assign do_copy = (commit_pending | coef_commit) & ~start & ~busy;

  // Shadow writes, shadow-to-active copy when the pipe is empty
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= 16'sd256; sh_b <= '0; sh_c <= '0;
      sh_d <= '0; sh_e <= 16'sd256; sh_f <= '0;
      ac_a <= 16'sd256; ac_b <= '0; ac_c <= '0;
      ac_d <= '0; ac_e <= 16'sd256; ac_f <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (coef_wr) begin
        case (coef_sel)
          3'd0:    sh_a <= coef_data[15:0];
          3'd1:    sh_b <= coef_data[15:0];
          3'd2:    sh_c <= coef_data;
          3'd3:    sh_d <= coef_data[15:0];
          3'd4:    sh_e <= coef_data[15:0];
          3'd5:    sh_f <= coef_data;
          default: ;
        endcase
      end
      if (do_copy) begin
        ac_a <= sh_a; ac_b <= sh_b; ac_c <= sh_c;
        ac_d <= sh_d; ac_e <= sh_e; ac_f <= sh_f;
        commit_pending <= 1'b0;
      end else if (coef_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Operand extension to product width
  always_comb begin
    xe  = {17'b0, s1_x};
    ye  = {17'b0, s1_y};
    a27 = {{11{ac_a[15]}}, ac_a};
    b27 = {{11{ac_b[15]}}, ac_b};
    d27 = {{11{ac_d[15]}}, ac_d};
    e27 = {{11{ac_e[15]}}, ac_e};
  end

  // Sums, rounding, bounds check and linear address
  always_comb begin
    sum_x = {{2{p_ax[26]}}, p_ax} + {{2{p_by[26]}}, p_by}
          + {{9{ac_c[19]}}, ac_c} + 29'sd128;
    sum_y = {{2{p_dx[26]}}, p_dx} + {{2{p_ey[26]}}, p_ey}
          + {{9{ac_f[19]}}, ac_f} + 29'sd128;
    sx    = sum_x[28:8];
    sy    = sum_y[28:8];
    oob_c = sx[20] | sy[20]
          | (sx[19:0] >= 20'(IMG_W))
          | (sy[19:0] >= 20'(IMG_H));
    addr_c = '0;
    if (!oob_c)
      addr_c = sy[18:0] * 19'(IMG_W) + sx[18:0];
  end

  assign unused_lsb = ^{sum_x[7:0], sum_y[7:0]};

  // S1 capture, S2 products, S3 mapped address
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_x <= '0; s1_y <= '0;
      s2_v <= 1'b0; s2_x <= '0; s2_y <= '0;
      p_ax <= '0; p_by <= '0; p_dx <= '0; p_ey <= '0;
      s3_v <= 1'b0; s3_oob <= 1'b0;
      s3_x <= '0; s3_y <= '0; s3_addr <= '0;
    end else begin
      s1_v <= start;
      s1_x <= query_x;
      s1_y <= query_y;
      s2_v <= s1_v;
      s2_x <= s1_x;
      s2_y <= s1_y;
      p_ax <= a27 * xe;
      p_by <= b27 * ye;
      p_dx <= d27 * xe;
      p_ey <= e27 * ye;
      s3_v    <= s2_v;
      s3_x    <= s2_x;
      s3_y    <= s2_y;
      s3_oob  <= oob_c;
      s3_addr <= addr_c;
    end
  end

  assign mem_rd   = s3_v & ~s3_oob;
  assign mem_addr = s3_addr;

  // Tags ride alongside the memory read latency
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_oob <= '0;
      tag_x   <= '0;
      tag_y   <= '0;
    end else begin
      tag_v[0]   <= s3_v;
      tag_oob[0] <= s3_oob;
      tag_x[0]   <= s3_x;
      tag_y[0]   <= s3_y;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_oob[i] <= tag_oob[i-1];
        tag_x[i]   <= tag_x[i-1];
        tag_y[i]   <= tag_y[i-1];
      end
    end
  end

  // Result registers hold between strobes
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      return_x <= '0;
      return_y <= '0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
    end else begin
      ready <= tag_v[L];
      if (tag_v[L]) begin
        return_x <= tag_x[L];
        return_y <= tag_y[L];
        r <= tag_oob[L] ? 5'd0 : mem_rdata[15:11];
        g <= tag_oob[L] ? 6'd0 : mem_rdata[10:5];
        b <= tag_oob[L] ? 5'd0 : mem_rdata[4:0];
      end
    end
  end

`ifdef HOMO_OOB_CNT_EN
  logic [15:0] oob_q;

  // Saturating count of out-of-bounds results
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)
      oob_q <= '0;
    else if (tag_v[L] && tag_oob[L] && oob_q != 16'hFFFF)
      oob_q <= oob_q + 16'd1;
  end

  assign oob_count = oob_q;
`else
  assign oob_count = '0;
`endif

endmodule
